// File: rtl/slot_reel_controller.sv
// Slot machine reel controller: runs three reels from start/stop buttons,
// divides the shared spinTick per reel, and judges the stopped combination.
//
// Handshake/timing contract: every button is a level input that acts once,
// on the clock edge where it is high and was low on the previous edge; a
// held button never re-triggers. spinTick is a single-cycle enable, sampled
// on the same edge. All outputs are registered; resultValid stays high from
// the judging edge until the next accepted start or reset.
//
// debugState encoding: 0 IDLE, 1 SPIN, 2 JUDGE, 3 RESULT.
module slot_reel_controller #(
    parameter int SYMBOLS    = 6,
    parameter int LEFT_DIV   = 1,
    parameter int MIDDLE_DIV = 2,
    parameter int RIGHT_DIV  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spinTick,
    input  logic       startButton,
    input  logic       stopLeft,
    input  logic       stopMiddle,
    input  logic       stopRight,
    output logic [2:0] left,
    output logic [2:0] middle,
    output logic [2:0] right,
    output logic [2:0] spinning,
    output logic [1:0] result,
    output logic       resultValid,
    output logic [1:0] debugState
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPIN   = 2'd1,
        ST_JUDGE  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t     state_q, state_d;

    // Reel arrays are indexed to line up with the spinning bits:
    // [2] left, [1] middle, [0] right.
    logic [2:0] reel_q [3];
    logic [2:0] reel_d [3];
    logic [3:0] cnt_q  [3];
    logic [3:0] cnt_d  [3];
    logic [2:0] spin_q, spin_d;
    logic [1:0] result_q, result_d;
    logic       valid_q, valid_d;

    logic       start_hist_q;
    logic [2:0] stop_hist_q;
    logic [2:0] stop_lvl;
    logic       start_ev;
    logic [2:0] stop_ev;

    assign stop_lvl = {stopLeft, stopMiddle, stopRight};
    assign start_ev = startButton & ~start_hist_q;
    assign stop_ev  = stop_lvl & ~stop_hist_q;

    // Last divider count before a reel advances.
    function automatic logic [3:0] div_last(input int idx);
        case (idx)
            2:       return 4'(LEFT_DIV - 1);
            1:       return 4'(MIDDLE_DIV - 1);
            default: return 4'(RIGHT_DIV - 1);
        endcase
    endfunction

    // Next symbol code, wrapping so the reserved blank code is never reached.
    function automatic logic [2:0] next_sym(input logic [2:0] s);
        return (s == 3'(SYMBOLS - 1)) ? 3'd0 : s + 3'd1;
    endfunction

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; SPIN leaves on the edge where the last reel stops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ev) state_d = ST_SPIN;
            ST_SPIN:   if (spin_d == 3'b000) state_d = ST_JUDGE;
            ST_JUDGE:  state_d = ST_RESULT;
            ST_RESULT: if (start_ev) state_d = ST_SPIN;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: reel stepping, stops, judging.
    always_comb begin
        reel_d   = reel_q;
        cnt_d    = cnt_q;
        spin_d   = spin_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE, ST_RESULT: begin
                if (start_ev) begin
                    spin_d   = 3'b111;
                    result_d = 2'b00;
                    valid_d  = 1'b0;
                    for (int i = 0; i < 3; i++) cnt_d[i] = 4'd0;
                end
            end
            ST_SPIN: begin
                for (int i = 0; i < 3; i++) begin
                    if (spin_q[i]) begin
                        // A stop on the same edge as a tick freezes the reel.
                        if (stop_ev[i]) begin
                            spin_d[i] = 1'b0;
                        end else if (spinTick) begin
                            if (cnt_q[i] == div_last(i)) begin
                                reel_d[i] = next_sym(reel_q[i]);
                                cnt_d[i]  = 4'd0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 4'd1;
                            end
                        end
                    end
                end
            end
            ST_JUDGE: begin
                valid_d = 1'b1;
                if (reel_q[2] == reel_q[1] && reel_q[1] == reel_q[0]) begin
                    result_d = 2'b11;
                end else if (reel_q[2] == reel_q[1] || reel_q[1] == reel_q[0] ||
                             reel_q[2] == reel_q[0]) begin
                    result_d = 2'b10;
                end else begin
                    result_d = 2'b01;
                end
            end
            default: ;
        endcase
    end

    // Datapath and button-history registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                reel_q[i] <= 3'd0;
                cnt_q[i]  <= 4'd0;
            end
            spin_q       <= 3'b000;
            result_q     <= 2'b00;
            valid_q      <= 1'b0;
            start_hist_q <= 1'b0;
            stop_hist_q  <= 3'b000;
        end else begin
            reel_q       <= reel_d;
            cnt_q        <= cnt_d;
            spin_q       <= spin_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            start_hist_q <= startButton;
            stop_hist_q  <= stop_lvl;
        end
    end

    assign left        = reel_q[2];
    assign middle      = reel_q[1];
    assign right       = reel_q[0];
    assign spinning    = spin_q;
    assign result      = result_q;
    assign resultValid = valid_q;
    assign debugState  = state_q;

endmodule

// File: tb/tb_slot_reel_controller.sv
// Bench for slot_reel_controller: directed vector table for the documented
// scenarios, then randomized buttons/ticks against a reel-position model.
module tb_slot_reel_controller;

    localparam int SYMBOLS = 6;
    // Model reel index: 0 left, 1 middle, 2 right.
    localparam int DIVS [3] = '{1, 2, 3};

    logic       clock = 1'b0;
    logic       reset, spinTick, startButton, stopLeft, stopMiddle, stopRight;
    logic [2:0] left, middle, right, spinning;
    logic [1:0] result, debugState;
    logic       resultValid;

    slot_reel_controller #(
        .SYMBOLS(SYMBOLS), .LEFT_DIV(1), .MIDDLE_DIV(2), .RIGHT_DIV(3)
    ) dut (
        .clock(clock), .reset(reset), .spinTick(spinTick),
        .startButton(startButton), .stopLeft(stopLeft),
        .stopMiddle(stopMiddle), .stopRight(stopRight),
        .left(left), .middle(middle), .right(right), .spinning(spinning),
        .result(result), .resultValid(resultValid), .debugState(debugState)
    );

    // Clock.
    always #5 clock = ~clock;

    // Packed observation: {left, middle, right, spinning, result, valid, state}.
    typedef struct {
        bit          rst, st, sl, sm, sr, tk;
        bit          chk;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void add(bit rst, bit st, bit sl, bit sm, bit sr, bit tk,
                                bit chk, int el, int em, int er, logic [2:0] es,
                                logic [1:0] ers, bit ev, int est);
        vec_t v;
        v.rst = rst; v.st = st; v.sl = sl; v.sm = sm; v.sr = sr; v.tk = tk;
        v.chk = chk;
        v.exp = {3'(el), 3'(em), 3'(er), es, ers, ev, 2'(est)};
        vecs.push_back(v);
    endfunction

    function automatic void adu(bit st, bit sl, bit sm, bit sr, bit tk);
        add(1'b0, st, sl, sm, sr, tk, 1'b0, 0, 0, 0, 3'b000, 2'b00, 1'b0, 0);
    endfunction

    // Reference model: a running reel's symbol is its start position plus
    // the number of whole divider periods seen, modulo the symbol count.
    int m_phase;  // 0 idle, 1 spin, 2 judge, 3 result
    int m_base[3], m_ticks[3], m_sym[3];
    bit m_run[3];
    int m_res;
    bit m_valid;
    bit m_pst;
    bit m_pstop[3];

    function automatic int cur_sym(int i);
        return m_run[i] ? (m_base[i] + m_ticks[i] / DIVS[i]) % SYMBOLS : m_sym[i];
    endfunction

    function automatic void model_step(bit rst, bit st, bit sl, bit sm, bit sr, bit tk);
        bit ev_st;
        bit ev_sp[3];
        bit lv[3];
        int distinct;
        lv[0] = sl; lv[1] = sm; lv[2] = sr;
        if (rst) begin
            m_phase = 0; m_res = 0; m_valid = 0; m_pst = 0;
            for (int i = 0; i < 3; i++) begin
                m_sym[i] = 0; m_run[i] = 0; m_base[i] = 0; m_ticks[i] = 0; m_pstop[i] = 0;
            end
            return;
        end
        ev_st = st && !m_pst;
        for (int i = 0; i < 3; i++) ev_sp[i] = lv[i] && !m_pstop[i];
        m_pst = st;
        for (int i = 0; i < 3; i++) m_pstop[i] = lv[i];
        case (m_phase)
            0, 3: if (ev_st) begin
                for (int i = 0; i < 3; i++) begin
                    m_base[i] = m_sym[i]; m_ticks[i] = 0; m_run[i] = 1;
                end
                m_res = 0; m_valid = 0; m_phase = 1;
            end
            1: begin
                for (int i = 0; i < 3; i++) begin
                    if (m_run[i]) begin
                        if (ev_sp[i]) begin
                            m_sym[i] = cur_sym(i);
                            m_run[i] = 0;
                        end else if (tk) begin
                            m_ticks[i]++;
                        end
                    end
                end
                if (!m_run[0] && !m_run[1] && !m_run[2]) m_phase = 2;
            end
            default: begin
                distinct = 3;
                if (m_sym[0] == m_sym[1] || m_sym[1] == m_sym[2] || m_sym[0] == m_sym[2])
                    distinct = 2;
                if (m_sym[0] == m_sym[1] && m_sym[1] == m_sym[2]) distinct = 1;
                m_res   = (distinct == 1) ? 3 : (distinct == 2) ? 2 : 1;
                m_valid = 1;
                m_phase = 3;
            end
        endcase
    endfunction

    function automatic logic [16:0] model_exp();
        return {3'(cur_sym(0)), 3'(cur_sym(1)), 3'(cur_sym(2)),
                {m_run[0], m_run[1], m_run[2]}, 2'(m_res), m_valid, 2'(m_phase)};
    endfunction

    function automatic string fmt(logic [16:0] x);
        return $sformatf("L%0d M%0d R%0d spin=%b res=%b valid=%b st=%0d",
                         x[16:14], x[13:11], x[10:8], x[7:5], x[4:3], x[2], x[1:0]);
    endfunction

    // Driver: called at a falling edge; applies inputs across one rising edge.
    task automatic drive(bit rst, bit st, bit sl, bit sm, bit sr, bit tk);
        reset = rst; startButton = st; stopLeft = sl; stopMiddle = sm;
        stopRight = sr; spinTick = tk;
        @(posedge clock);
        model_step(rst, st, sl, sm, sr, tk);
        @(negedge clock);
    endtask

    // Scoreboard compare.
    task automatic check(string name, logic [16:0] exp);
        logic [16:0] got;
        got = {left, middle, right, spinning, result, resultValid, debugState};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
    endtask

    bit r_rst, r_st, r_sl, r_sm, r_sr, r_tk;

    initial begin
        reset = 1'b1; spinTick = 1'b0; startButton = 1'b0;
        stopLeft = 1'b0; stopMiddle = 1'b0; stopRight = 1'b0;

        // Reset, single start from a held button, 12 ticks free-running.
        add(1,0,0,0,0,0, 1, 0,0,0, 3'b000, 2'b00, 0, 0);
        add(0,1,0,0,0,0, 1, 0,0,0, 3'b111, 2'b00, 0, 1);
        for (int i = 0; i < 4; i++) add(0,1,0,0,0,0, 1, 0,0,0, 3'b111, 2'b00, 0, 1);
        add(0,0,0,0,0,0, 1, 0,0,0, 3'b111, 2'b00, 0, 1);
        for (int k = 1; k <= 12; k++)
            add(0,0,0,0,0,1, 1, k % 6, (k / 2) % 6, (k / 3) % 6, 3'b111, 2'b00, 0, 1);

        // Stop right on its advance edge, then a pair at 1,3,1.
        add(1,0,0,0,0,0, 1, 0,0,0, 3'b000, 2'b00, 0, 0);
        add(0,1,0,0,0,0, 1, 0,0,0, 3'b111, 2'b00, 0, 1);
        add(0,0,0,0,0,0, 1, 0,0,0, 3'b111, 2'b00, 0, 1);
        for (int k = 0; k < 5; k++) adu(0,0,0,0,1);
        add(0,0,0,0,1,1, 1, 0,3,1, 3'b110, 2'b00, 0, 1);
        add(0,0,0,0,0,1, 1, 1,3,1, 3'b110, 2'b00, 0, 1);
        add(0,0,1,1,0,1, 1, 1,3,1, 3'b000, 2'b00, 0, 2);
        add(0,0,0,0,0,0, 1, 1,3,1, 3'b000, 2'b10, 1, 3);
        add(0,0,1,1,1,1, 1, 1,3,1, 3'b000, 2'b10, 1, 3);
        add(0,0,0,0,0,0, 1, 1,3,1, 3'b000, 2'b10, 1, 3);
        add(0,1,0,0,0,0, 1, 1,3,1, 3'b111, 2'b00, 0, 1);
        add(0,0,0,0,0,0, 1, 1,3,1, 3'b111, 2'b00, 0, 1);

        // Staggered stops landing on 0,1,2 (lose).
        for (int k = 0; k < 4; k++) adu(0,0,0,0,1);
        add(0,0,0,0,1,0, 1, 5,5,2, 3'b110, 2'b00, 0, 1);
        for (int k = 0; k < 4; k++) adu(0,0,0,0,1);
        add(0,0,0,1,0,0, 1, 3,1,2, 3'b100, 2'b00, 0, 1);
        for (int k = 0; k < 3; k++) adu(0,0,0,0,1);
        add(0,0,1,0,0,0, 1, 0,1,2, 3'b000, 2'b00, 0, 2);
        add(0,0,0,0,0,0, 1, 0,1,2, 3'b000, 2'b01, 1, 3);
        add(0,1,0,0,0,0, 1, 0,1,2, 3'b111, 2'b00, 0, 1);

        // Resume to 2,2,2, all three stopped together on a tick edge.
        add(0,0,0,0,0,1, 1, 1,1,2, 3'b111, 2'b00, 0, 1);
        add(0,0,0,0,0,1, 1, 2,2,2, 3'b111, 2'b00, 0, 1);
        add(0,0,1,1,1,1, 1, 2,2,2, 3'b000, 2'b00, 0, 2);
        add(0,0,0,0,0,0, 1, 2,2,2, 3'b000, 2'b11, 1, 3);

        // Reset mid-spin at 3,4,5 with a stop and tick in the same cycle.
        add(1,0,0,0,0,0, 1, 0,0,0, 3'b000, 2'b00, 0, 0);
        add(0,1,0,0,0,0, 1, 0,0,0, 3'b111, 2'b00, 0, 1);
        add(0,0,0,0,0,0, 1, 0,0,0, 3'b111, 2'b00, 0, 1);
        for (int k = 0; k < 8; k++) adu(0,0,0,0,1);
        add(0,0,0,1,0,0, 1, 2,4,2, 3'b101, 2'b00, 0, 1);
        for (int k = 0; k < 6; k++) adu(0,0,0,0,1);
        add(0,0,0,0,0,1, 1, 3,4,5, 3'b101, 2'b00, 0, 1);
        add(1,0,1,0,0,1, 1, 0,0,0, 3'b000, 2'b00, 0, 0);
        add(0,0,1,0,0,1, 1, 0,0,0, 3'b000, 2'b00, 0, 0);
        add(0,0,0,0,0,1, 1, 0,0,0, 3'b000, 2'b00, 0, 0);

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].sl, vecs[i].sm, vecs[i].sr, vecs[i].tk);
            if (vecs[i].chk) check($sformatf("row%0d", i), vecs[i].exp);
        end

        // Randomized buttons and ticks against the model.
        drive(1, 0, 0, 0, 0, 0);
        check("rand_reset", model_exp());
        r_st = 0; r_sl = 0; r_sm = 0; r_sr = 0;
        for (int c = 0; c < 4000; c++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) r_st = ~r_st;
            if ($urandom_range(0, 5) == 0) r_sl = ~r_sl;
            if ($urandom_range(0, 5) == 0) r_sm = ~r_sm;
            if ($urandom_range(0, 5) == 0) r_sr = ~r_sr;
            r_tk = 1'($urandom_range(0, 1));
            drive(r_rst, r_st, r_sl, r_sm, r_sr, r_tk);
            check($sformatf("rand%0d", c), model_exp());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/slot_reel_controller.md
Name: slot_reel_controller

Overview:
- Upstream stage of the slot machine display path. Runs the three reels (left, middle, right) from player start/stop buttons and holds each reel's symbol code.
- Judges the final combination when all three reels have stopped.
- Its left/middle/right outputs feed the dynamic-lighting multiplexer directly. Each output is a 3-bit symbol code in 0..SYMBOLS-1; code 3'b111 is reserved downstream as blank and is never produced.

Parameters:
- SYMBOLS, 6: number of symbols per reel. Legal range 2..7. Codes wrap from SYMBOLS-1 to 0.
- LEFT_DIV, 1: left reel advances once per LEFT_DIV spinTick pulses. Range 1..15.
- MIDDLE_DIV, 2: same, for the middle reel.
- RIGHT_DIV, 3: same, for the right reel.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- spinTick  in  1  one-cycle reel-step enable from the prescaler.
- startButton  in  1  debounced level; acts on its rising edge.
- stopLeft  in  1  debounced level; acts on its rising edge.
- stopMiddle  in  1  debounced level; acts on its rising edge.
- stopRight  in  1  debounced level; acts on its rising edge.
- left  out  3  left reel symbol (registered).
- middle  out  3  middle reel symbol (registered).
- right  out  3  right reel symbol (registered).
- spinning  out  3  {left, middle, right} reel-running flags.
- result  out  2  00 none, 01 lose, 10 pair, 11 jackpot.
- resultValid  out  1  high while result holds a judged outcome.

Behaviour:
- Reset (synchronous, active-high; clock and reset exactly as named above):
  - left = middle = right = 0; spinning = 000; result = 00; resultValid = 0.
  - State = IDLE; divider counters = 0; button-history registers = 0.
  - Reset wins over every other input in the same cycle, including mid-spin. Reels freeze at 0 and no judgement is made.
- Edge detection: each button has a history register. An event is level=1 with history=0, evaluated at a clock edge; history updates every cycle. A held button produces exactly one event.
- States: IDLE, SPIN, JUDGE, RESULT.
- IDLE:
  - Reels hold their values; stop events are ignored.
  - Start event: go to SPIN, spinning <= 111, clear all divider counters, result <= 00, resultValid <= 0.
- SPIN:
  - Per reel, while its spinning bit is 1: on a spinTick edge, if the divider count = DIV-1 the symbol advances (wrapping SYMBOLS-1 -> 0) and the count clears; otherwise the count increments. No spinTick means no change.
  - A stop event for a reel clears its spinning bit. The reel does not advance on that same edge, even with spinTick: stop wins.
  - Stop events for already-stopped reels are ignored. Simultaneous stops are all honoured on the same edge.
  - Start events in SPIN are ignored.
  - When the registered spinning value becomes 000, the next state is JUDGE.
- JUDGE: one cycle. At its exit edge:
  - all three reels equal -> result 11;
  - exactly two equal -> 10;
  - else -> 01.
  - resultValid <= 1 and the state moves to RESULT. Buttons are ignored in JUDGE.
- RESULT:
  - result and reels hold; stop events are ignored.
  - Start event: same actions as the start event in IDLE (reels resume from their held values).
- Latency:
  - Start edge to spinning = 111: visible one cycle later.
  - Last stop edge to resultValid = 1: 2 edges (one edge to spinning = 000 / JUDGE, one to RESULT).
- Invariant: reel values are never >= SYMBOLS, and never 3'b111.

Test Plan:
- Reset, then startButton 0->1 held 5 cycles -> spinning = 111 after one edge, a single start event only, result = 00, resultValid = 0.
- SPIN with default divisors, 12 spinTick pulses and no stops -> left = 0 (12 mod 6), middle = 0 (6 steps), right = 4 (4 steps).
- Stop right while spinTick is high on a right-advance edge -> right unchanged, spinning = 110.
- Stop all three on the same edge with reels at 2,2,2 -> spinning = 000, then JUDGE, then result = 11 and resultValid = 1 two edges after the stops.
- Reels stopped at 1,3,1 -> result 10; at 0,1,2 -> result 01. A start pressed in RESULT -> spinning = 111, resultValid = 0.
- Reset asserted mid-SPIN with reels at 3,4,5 and a stop pressed the same cycle -> all reels 0, spinning = 000, IDLE, resultValid = 0.
